// File: rtl/jump_controller_if.sv
// Button/landing handshake bundle between the board-side driver and the jump controller.
// The controller connects through the slave modport; whoever drives buttons and landed uses master.
interface jump_controller_if;
    logic        module_en;
    logic        btn_left;
    logic        btn_right;
    logic        landed;
    logic        one_ms_tick;
    logic        jump_left;
    logic        jump_right;
    logic        busy;
    logic [15:0] jump_count;
    logic        timeout_err;

    modport master (
        output module_en, btn_left, btn_right, landed,
        input  one_ms_tick, jump_left, jump_right, busy, jump_count, timeout_err
    );

    modport slave (
        input  module_en, btn_left, btn_right, landed,
        output one_ms_tick, jump_left, jump_right, busy, jump_count, timeout_err
    );
endinterface

// File: rtl/jump_controller.sv
// Turns debounced left/right button presses into single-cycle jump commands, one in flight at a time,
// with a one-deep press buffer, completed-jump counter, landing timeout and the shared 1 ms tick.
module jump_controller #(
    parameter int CLK_FREQ_HZ = 40_000_000,
    parameter int DEBOUNCE_MS = 5,
    parameter int TIMEOUT_MS  = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    jump_controller_if.slave bus
);
    localparam int                TICK_CYCLES  = CLK_FREQ_HZ / 1000;
    localparam int                TICK_W       = $clog2(TICK_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_CYCLES - 1);
    localparam logic [3:0]        DEB_LAST     = 4'(DEBOUNCE_MS - 1);
    localparam logic [7:0]        TIMEOUT_LAST = 8'(TIMEOUT_MS - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    // Index 0 is the left button, index 1 the right button.
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] deb;
    logic [3:0] deb_cnt [2];
    logic [1:0] deb_done;
    logic [1:0] press;
    logic       press_any;
    logic       press_dir;

    state_t      state;
    logic        buf_valid;
    logic        buf_dir;
    logic [7:0]  to_cnt;
    logic [15:0] count_q;
    logic        jump_left_q;
    logic        jump_right_q;
    logic        busy_q;
    logic        err_q;

    assign tick            = (tick_cnt == TICK_LAST);
    assign bus.one_ms_tick = tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign raw = {bus.btn_right, bus.btn_left};

    // A level is accepted only after it differs from the debounced level for DEBOUNCE_MS ticks in a row.
    assign deb_done  = (sync2 ^ deb) & {2{tick}}
                     & {deb_cnt[1] == DEB_LAST, deb_cnt[0] == DEB_LAST};
    assign press     = deb_done & sync2;
    assign press_any = |press;
    assign press_dir = ~press[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_done[i]) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else if (tick) begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Direction encoding throughout: 0 = left, 1 = right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            buf_valid    <= 1'b0;
            buf_dir      <= 1'b0;
            to_cnt       <= '0;
            count_q      <= '0;
            jump_left_q  <= 1'b0;
            jump_right_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            jump_left_q  <= 1'b0;
            jump_right_q <= 1'b0;
            if (!bus.module_en) begin
                state     <= IDLE;
                buf_valid <= 1'b0;
                buf_dir   <= 1'b0;
                to_cnt    <= '0;
                count_q   <= '0;
                busy_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A buffered press takes priority; a fresh press arriving alongside it is dropped.
                        if (buf_valid) begin
                            jump_left_q  <= ~buf_dir;
                            jump_right_q <= buf_dir;
                            buf_valid    <= 1'b0;
                            to_cnt       <= '0;
                            state        <= WAIT;
                            busy_q       <= 1'b1;
                        end else if (press_any) begin
                            jump_left_q  <= ~press_dir;
                            jump_right_q <= press_dir;
                            to_cnt       <= '0;
                            state        <= WAIT;
                            busy_q       <= 1'b1;
                        end else begin
                            busy_q <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (bus.landed) begin
                            if (count_q != 16'hFFFF) begin
                                count_q <= count_q + 1'b1;
                            end
                            state <= IDLE;
                            if (!buf_valid && press_any) begin
                                buf_valid <= 1'b1;
                                buf_dir   <= press_dir;
                                busy_q    <= 1'b1;
                            end else begin
                                busy_q <= buf_valid;
                            end
                        end else if (tick && (to_cnt == TIMEOUT_LAST)) begin
                            err_q     <= 1'b1;
                            buf_valid <= 1'b0;
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            if (tick) begin
                                to_cnt <= to_cnt + 1'b1;
                            end
                            if (!buf_valid && press_any) begin
                                buf_valid <= 1'b1;
                                buf_dir   <= press_dir;
                            end
                            busy_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.jump_left   = jump_left_q;
    assign bus.jump_right  = jump_right_q;
    assign bus.busy        = busy_q;
    assign bus.jump_count  = count_q;
    assign bus.timeout_err = err_q;
endmodule

// File: doc/jump_controller.md
Name: jump_controller

Overview:
- Initiator side of the character jump handshake: turns raw left/right buttons into single-cycle jump_left/jump_right commands.
- Waits for the character's landed pulse before issuing the next command.
- Also generates the shared one_ms_tick.
- Sits between the board button inputs and the character block. It holds one buffered press, counts completed jumps, and flags a missing landed response.

Parameters:
- CLK_FREQ_HZ, 40_000_000, pixel clock frequency; tick period is CLK_FREQ_HZ/1000 cycles (integer, ≥2).
- DEBOUNCE_MS, 5, consecutive ms ticks a synchronised button level must hold before it is accepted (1..15).
- TIMEOUT_MS, 100, ms ticks allowed in WAIT without landed before error (2..255).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- module_en  in  1  game running; low = hold controller in idle/cleared
- btn_left  in  1  raw asynchronous button
- btn_right  in  1  raw asynchronous button
- landed  in  1  one-cycle pulse from character: jump finished
- one_ms_tick  out  1  one-cycle pulse every CLK_FREQ_HZ/1000 cycles
- jump_left  out  1  one-cycle jump command
- jump_right  out  1  one-cycle jump command
- busy  out  1  jump in flight or press buffered
- jump_count  out  16  completed jumps since enable, saturating
- timeout_err  out  1  sticky: landed not received within TIMEOUT_MS

Behaviour:

Reset (rst_n low, asynchronous):
- All outputs 0.
- Tick divider 0, debounce counters 0, debounced levels 0, sync flops 0.
- State IDLE, buffer empty.

Tick divider:
- Free-running whenever rst_n high, independent of module_en.
- Counts 0..CLK_FREQ_HZ/1000-1; one_ms_tick high in the cycle the counter equals terminal count, then wraps to 0.
- First tick is in cycle CLK_FREQ_HZ/1000 after reset release.

Debounce (per button, independent of module_en):
- 2-flop synchroniser.
- When the synced level ≠ debounced level, count one_ms_ticks; any cycle where they are equal clears the count.
- When the count reaches DEBOUNCE_MS, the debounced level takes the synced level and the count clears.
- Press event = debounced level 0→1 in that cycle; release is ignored.

FSM, states IDLE and WAIT:
- jump_left/jump_right are registered: high in the cycle after the issuing decision, for exactly one cycle, never both.
- IDLE:
  - If buffer valid: issue the buffered direction, clear buffer, go to WAIT, clear timeout counter.
  - Else on a press event: issue it, go to WAIT.
  - landed in IDLE is ignored.
- WAIT:
  - On landed: jump_count += 1 (hold at 0xFFFF), go to IDLE.
  - A press event while buffer empty stores its direction; further presses are dropped while the buffer is full (first wins).
  - A press event in the same cycle as landed is buffered, then issued from IDLE on the next cycle.
  - Each one_ms_tick increments the timeout counter. If it reaches TIMEOUT_MS with no landed: set timeout_err, clear buffer, go to IDLE.
  - landed and the final timeout tick in the same cycle: landed wins, no error.
- Left and right press events in the same cycle: left wins, right dropped (both for issue and buffer).
- module_en low (synchronous, overrides all):
  - State IDLE, buffer cleared, no jump issued.
  - jump_count = 0, timeout_err = 0.
  - Press events are discarded.
- busy = (state == WAIT) | buffer valid, registered.

Latency:
- Press event in cycle N (IDLE, empty buffer) → jump_x high in cycle N+1, busy high in N+1.

Test Plan (bench uses CLK_FREQ_HZ=10_000, so 10 cycles/tick; DEBOUNCE_MS=3; TIMEOUT_MS=8):
- Reset release → one_ms_tick high at cycle 10, 20, 30…; all other outputs 0.
- module_en=1; btn_right held high → exactly one jump_right pulse about 3 ticks after sync, busy=1; landed pulse 5 ticks later → jump_count=1, busy=0 next cycle. A 2-tick glitch on btn_left produces no pulse.
- In WAIT: press left then right before landed → on landed, jump_left is issued 2 cycles later (IDLE pass), right is dropped, jump_count=1, busy stays 1.
- Both buttons pressed in the same cycle while IDLE → jump_left only.
- No landed for 8 ticks after issue → timeout_err=1, state IDLE, buffered press discarded. A later press issues normally with timeout_err still 1; module_en low for 1 cycle → timeout_err=0, jump_count=0.
- Assert rst_n low mid-WAIT asynchronously (between clock edges) → outputs 0 immediately. Force jump_count to 0xFFFF, then one more landed → stays 0xFFFF.
